fir_mac_sched: RTL

//  Sequencer sharing one FPALU between the multiply and accumulate phases of one FIR output.
//  - Fetches TAPS sample/coefficient pairs and issues TAPS back-to-back FP16i multiplies.
//  - Buffers the FP29i products, then chains TAPS-1 dependent adds; the last add normalizes.
//  - Sits between the sample delay line / coefficient store and the FPALU.

---
 rtl/fir_mac_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: shares one FPALU between the TAPS multiplies and TAPS-1 chained adds of one FIR output
module fir_mac_sched #(
   parameter int TAPS = 8,
   parameter int LAT  = 5,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] tap_addr,
   input  logic          x_sgn,
   input  logic [4:0]    x_exp,
   input  logic [10:0]   x_man,
   input  logic          c_sgn,
   input  logic [4:0]    c_exp,
   input  logic [10:0]   c_man,
   output logic [1:0]    alu_op,
   output logic          alu_issue,
   output logic          alu_a_sgn,
   output logic [5:0]    alu_a_exp,
   output logic [21:0]   alu_a_man,
   output logic          alu_b_sgn,
   output logic [5:0]    alu_b_exp,
   output logic [21:0]   alu_b_man,
   input  logic          alu_y_sgn,
   input  logic [5:0]    alu_y_exp,
   input  logic [21:0]   alu_y_man,
   output logic          y_sgn,
   output logic [5:0]    y_exp,
   output logic [21:0]   y_man,
   output logic          y_valid
);
   localparam int LW = $clog2(LAT) + 1;
   typedef enum logic [2:0] {IDLE, MUL, DRAIN, ACC, WAITACC, FIN} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] k_q, k_d, wr_q, wr_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [LAT-1:0] tag_q, tag_d;
   logic [28:0] acc_q, acc_d, y_q, y_d, alu_y;
   logic [59:0] opnd_q, opnd_d, opnd_new;
   logic [28:0] prod_q [TAPS];
   logic mul, issue, cap, last;
   assign alu_y = {alu_y_sgn, alu_y_exp, alu_y_man};
   assign mul = state_q == MUL;
   assign issue = mul || state_q == ACC;
   assign cap = tag_q[LAT-1];
   assign last = k_q == AW'(TAPS - 1);
   // op, operand A, operand B as one bundle so idle cycles hold the last issued values
   assign opnd_new = mul ? {2'b10, x_sgn, 1'b0, x_exp, 11'b0, x_man, c_sgn, 1'b0, c_exp, 11'b0, c_man}
                         : {last ? 2'b00 : 2'b11, acc_q, prod_q[k_q]};
   assign opnd_d = issue ? opnd_new : opnd_q;
   assign {alu_op, alu_a_sgn, alu_a_exp, alu_a_man, alu_b_sgn, alu_b_exp, alu_b_man} = opnd_d;
   assign alu_issue = issue;
   assign tap_addr = mul ? k_q : '0;
   assign busy = state_q != IDLE;
   assign done = state_q == FIN;
   assign y_valid = state_q == FIN;
   assign {y_sgn, y_exp, y_man} = y_q;
   always_comb begin
      state_d = state_q;
      k_d = k_q;
      wr_d = wr_q;
      lat_d = lat_q;
      acc_d = acc_q;
      y_d = y_q;
      tag_d = LAT'({tag_q, mul});
      if (cap) begin
         wr_d = wr_q + 1'b1;
         if (wr_q == '0) acc_d = alu_y;
      end
      case (state_q)
         IDLE: if (start) begin
            state_d = MUL;
            k_d = '0;
            wr_d = '0;
         end
         MUL: if (last) state_d = DRAIN;
              else k_d = k_q + 1'b1;
         DRAIN: if (cap && wr_q == AW'(TAPS - 1)) begin
            state_d = ACC;
            k_d = AW'(1);
         end
         ACC: begin
            state_d = WAITACC;
            lat_d = '0;
         end
         WAITACC: if (lat_q == LW'(LAT - 1)) begin
            acc_d = alu_y;
            if (last) begin
               y_d = alu_y;
               state_d = FIN;
            end else begin
               state_d = ACC;
               k_d = k_q + 1'b1;
            end
         end else lat_d = lat_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q <= '0;
         wr_q <= '0;
         lat_q <= '0;
         tag_q <= '0;
         acc_q <= '0;
         y_q <= '0;
         opnd_q <= {2'b10, 58'b0};
      end else begin
         state_q <= state_d;
         k_q <= k_d;
         wr_q <= wr_d;
         lat_q <= lat_d;
         tag_q <= tag_d;
         acc_q <= acc_d;
         y_q <= y_d;
         opnd_q <= opnd_d;
      end
   end
   always_ff @(posedge clk) if (cap) prod_q[wr_q] <= alu_y;
endmodule
